rgb_to_yuv444: RTL
==================

// Module: rgb_to_yuv444
// PURPOSE
// - Streaming colour-space converter: packed RGB888 (2 px/beat) -> packed Y'UV444 (BT.601 studio range).
// - Encoder counterpart of the YUV444->RGB stage; sits in the video DMA/chain between frame reader and encoder stages.
// - 4-stage handshaked pipeline, full throughput (1 beat/cycle), bubble-collapsing.
// PARAMETERS
// DATA_WIDTH  64  stream data width; only 64 supported (2 pixels x 32 bit)
// USER_WIDTH  1   t_user width; bit0 = chain-route flag
// DEST_WIDTH  1   t_dest width
// CHAIN_ID    0   t_dest value emitted when incoming t_user[0]=1
// PORTS
// aclk     in   1   clock, all logic on rising edge
// areset   in   1   reset, synchronous, active-high
// src      nasti_stream_channel.slave   RGB input: t_data[0], t_valid, t_ready, t_last, t_user, t_keep, t_strb
// dst      nasti_stream_channel.master  YUV output: t_data[0], t_valid, t_ready, t_last, t_user, t_dest, t_keep, t_strb, t_id
// BEHAVIOUR
// - Input pixel p (p=0,1) at bits [32p+:32]: B [7:0], G [15:8], R [23:16], byte3 ignored.
// - Output pixel p: V [7:0], U [15:8], Y [23:16], byte3 = 8'h00.
// - Arithmetic (signed 32-bit, >>> arithmetic shift, floor):
//   Y = ((66R + 129G + 25B + 128) >>> 8) + 16
//   U = ((-38R - 74G + 112B + 128) >>> 8) + 128
//   V = ((112R - 94G - 18B + 128) >>> 8) + 128
//   result clamped to [0,255] before packing (never active in studio mode; kept for full-range).
// - Stages: S1 capture R,G,B; S2 9 products/pixel; S3 sum, +128, >>>8; S4 offset, clamp, dst register.
// - Latency: accepted src beat -> dst.t_valid = 4 cycles with dst.t_ready held 1.
// - Per-stage valid flag v1..v3 plus dst.t_valid. Stage k advances when v_k && (next stage empty || next advancing).
// - src.t_ready = !v1 || S1 advancing (combinational from downstream; no src.t_valid dependency).
// - dst.t_valid stays 1, data/last/user/dest stable, until dst.t_ready; no beat dropped or duplicated.
// - Simultaneous load and drain of a stage: load wins, valid stays 1.
// - Sidebands travel with data: t_last unchanged; dst.t_user = src.t_user >> 1;
//   dst.t_dest = src.t_user[0] ? CHAIN_ID : 0.
// - dst.t_keep='1, dst.t_strb='1, dst.t_id='0 constant.
// - src beat with any t_keep/t_strb bit 0: simulation $error, beat still converted.
// - Reset: v1..v3=0, dst.t_valid=0, dst.t_last=0 on the cycle after areset sampled 1; data regs not reset.
// - areset mid-frame: all in-flight beats discarded, no partial output; src.t_ready=1 the cycle after release.
// CONFIGURATION
// - RGB2YUV_FULL_RANGE_EN undefined: studio-range coefficients above (Y 16..235, U/V 16..240).
// - RGB2YUV_FULL_RANGE_EN defined: JPEG full-range coefficients, same pipeline/latency:
//   Y = (77R + 150G + 29B + 128) >>> 8;  U = ((-43R - 85G + 128B + 128) >>> 8) + 128;
//   V = ((128R - 107G - 21B + 128) >>> 8) + 128;  clamp to [0,255] required (blue U -> 255).
// TESTING
// - Black/white: px0 RGB(0,0,0), px1 RGB(255,255,255) -> px0 Y/U/V=16/128/128, px1 235/128/128, byte3=0.
// - Primaries: red(255,0,0) -> 82/90/240; green(0,255,0) -> 144/54/34; blue(0,0,255) -> 41/240/110.
// - Throughput: 100 back-to-back beats, dst.t_ready=1 -> first out at cycle 4, then 1 beat/cycle, order kept.
// - Backpressure: random dst.t_ready (50%) + random src.t_valid -> scoreboard exact, dst stable while stalled.
// - Sidebands: t_last on beat 7, t_user=1 with CHAIN_ID=3 -> dst.t_last on beat 7 only, t_dest=3, t_user=0.
// - Reset: assert areset with 3 beats in flight and dst stalled -> dst.t_valid=0 next cycle, none emitted later.
// - Full-range build: white -> 255/128/128; blue(0,0,255) -> 29/255/107.

Source files
------------

// File: rtl/rgb_to_yuv444.sv
// Streaming RGB888 -> Y'UV444 converter, 2 pixels per 64-bit beat, 4-stage handshaked pipeline.
// Define RGB2YUV_FULL_RANGE_EN for JPEG full-range coefficients; the default is BT.601 studio range.
module rgb_to_yuv444 #(
   parameter int DATA_WIDTH = 64,
   parameter int USER_WIDTH = 1,
   parameter int DEST_WIDTH = 1,
   parameter int CHAIN_ID   = 0
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic [DATA_WIDTH-1:0]   src_t_data,
   input  logic                    src_t_valid,
   output logic                    src_t_ready,
   input  logic                    src_t_last,
   input  logic [USER_WIDTH-1:0]   src_t_user,
   input  logic [DATA_WIDTH/8-1:0] src_t_keep,
   input  logic [DATA_WIDTH/8-1:0] src_t_strb,
   output logic [DATA_WIDTH-1:0]   dst_t_data,
   output logic                    dst_t_valid,
   input  logic                    dst_t_ready,
   output logic                    dst_t_last,
   output logic [USER_WIDTH-1:0]   dst_t_user,
   output logic [DEST_WIDTH-1:0]   dst_t_dest,
   output logic [DATA_WIDTH/8-1:0] dst_t_keep,
   output logic [DATA_WIDTH/8-1:0] dst_t_strb,
   output logic                    dst_t_id
);

   typedef logic signed [31:0] word_t;

`ifdef RGB2YUV_FULL_RANGE_EN
   localparam int signed OFF_Y = 0;
   localparam int signed COEF [9] = '{77, 150, 29, -43, -85, 128, 128, -107, -21};
`else
   localparam int signed OFF_Y = 16;
   localparam int signed COEF [9] = '{66, 129, 25, -38, -74, 112, 112, -94, -18};
`endif
   localparam int signed OFFS [3] = '{OFF_Y, 128, 128};

   function automatic logic [7:0] clamp8(input word_t x);
      if (x < 0)
         return 8'd0;
      else if (x > 255)
         return 8'd255;
      else
         return x[7:0];
   endfunction

   // Per pixel: channel index 0=R 1=G 2=B; output index 0=Y 1=U 2=V.
   logic [7:0]            s1_c    [2][3];
   word_t                 s2_prod [2][9];
   word_t                 s3_sum  [2][3];
   logic [DATA_WIDTH-1:0] s4_data;

   logic                  s1_last, s2_last, s3_last;
   logic [USER_WIDTH-1:0] s1_user, s2_user, s3_user;
   logic [DEST_WIDTH-1:0] s1_dest, s2_dest, s3_dest;

   logic v1, v2, v3;
   logic load1, adv1, adv2, adv3, adv4;

   // Ready ripples back from dst; a stage may take a new beat whenever it is empty or draining.
   assign adv4        = dst_t_valid & dst_t_ready;
   assign adv3        = v3 & (~dst_t_valid | dst_t_ready);
   assign adv2        = v2 & (~v3 | adv3);
   assign adv1        = v1 & (~v2 | adv2);
   assign src_t_ready = ~v1 | adv1;
   assign load1       = src_t_valid & src_t_ready;

   assign dst_t_keep = '1;
   assign dst_t_strb = '1;
   assign dst_t_id   = 1'b0;

   // NOTE: registers use non-blocking assignments so every stage samples the pre-edge value of its predecessor.
   always_ff @(posedge aclk) begin
      if (areset) begin
         v1          <= 1'b0;
         v2          <= 1'b0;
         v3          <= 1'b0;
         dst_t_valid <= 1'b0;
         dst_t_last  <= 1'b0;
      end else begin
         // Load has priority over drain, so a stage that does both stays valid.
         if (load1)     v1 <= 1'b1;
         else if (adv1) v1 <= 1'b0;
         if (adv1)      v2 <= 1'b1;
         else if (adv2) v2 <= 1'b0;
         if (adv2)      v3 <= 1'b1;
         else if (adv3) v3 <= 1'b0;
         if (adv3)      dst_t_valid <= 1'b1;
         else if (adv4) dst_t_valid <= 1'b0;
         if (adv3)      dst_t_last <= s3_last;
      end
   end

   // NOTE: datapath registers carry no reset; their contents are qualified by the valid flags.
   always_ff @(posedge aclk) begin
      if (load1) begin
         for (int p = 0; p < 2; p++) begin
            s1_c[p][0] <= src_t_data[32*p+16 +: 8];
            s1_c[p][1] <= src_t_data[32*p+8 +: 8];
            s1_c[p][2] <= src_t_data[32*p +: 8];
         end
         s1_last <= src_t_last;
         s1_user <= src_t_user >> 1;
         s1_dest <= src_t_user[0] ? DEST_WIDTH'(CHAIN_ID) : '0;
      end
      if (adv1) begin
         for (int p = 0; p < 2; p++)
            for (int k = 0; k < 9; k++)
               s2_prod[p][k] <= COEF[k] * word_t'({24'd0, s1_c[p][k % 3]});
         s2_last <= s1_last;
         s2_user <= s1_user;
         s2_dest <= s1_dest;
      end
      if (adv2) begin
         for (int p = 0; p < 2; p++)
            for (int o = 0; o < 3; o++)
               s3_sum[p][o] <= (s2_prod[p][3*o] + s2_prod[p][3*o+1] + s2_prod[p][3*o+2]
                                + 32'sd128) >>> 8;
         s3_last <= s2_last;
         s3_user <= s2_user;
         s3_dest <= s2_dest;
      end
      if (adv3) begin
         dst_t_data <= s4_data;
         dst_t_user <= s3_user;
         dst_t_dest <= s3_dest;
      end
   end

   // NOTE: defaulting every output first keeps this combinational block free of latches.
   always_comb begin
      s4_data = '0;
      for (int p = 0; p < 2; p++) begin
         s4_data[32*p+16 +: 8] = clamp8(s3_sum[p][0] + OFFS[0]);
         s4_data[32*p+8 +: 8]  = clamp8(s3_sum[p][1] + OFFS[1]);
         s4_data[32*p +: 8]    = clamp8(s3_sum[p][2] + OFFS[2]);
      end
   end

   // Byte 3 of each input pixel is padding.
   logic unused_inputs;
   assign unused_inputs = ^{src_t_data[63:56], src_t_data[31:24], src_t_keep, src_t_strb};

   // Partial beats are still converted; flag them so the upstream bug is visible in simulation.
   always @(posedge aclk) begin
      if (!areset && load1)
         assert (&src_t_keep && &src_t_strb)
         else $error("rgb_to_yuv444: input beat with partial t_keep/t_strb");
   end

endmodule
